// File: rtl/piso_pkg.sv
// Shared definitions for the PISO frame controller: state encodings and a counter-width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } piso_state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int piso_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_frame_controller_if.sv
// Word-in / serial-out bundle between a word source (master) and the frame controller (slave).
interface piso_frame_controller_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;
    logic             i_tick;
    logic             o_sdata;
    logic             o_svalid;
    logic             o_sfirst;
    logic             o_slast;
    logic             o_done;

    modport master (
        output i_data, i_valid, i_tick,
        input  o_ready, o_sdata, o_svalid, o_sfirst, o_slast, o_done
    );

    modport slave (
        input  i_data, i_valid, i_tick,
        output o_ready, o_sdata, o_svalid, o_sfirst, o_slast, o_done
    );
endinterface

// File: rtl/piso_shreg.sv
// WIDTH-bit shift register: parallel load has priority over a zero-filling right shift; bit 0 is the serial output.
module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shifted[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= din;
        end else if (shift) begin
            shreg_reg <= shifted;
        end
    end

    assign sout = shreg_reg[0];
endmodule

// File: rtl/piso_frame_controller.sv
// Frame sequencer for a PISO shift register: handshake accept, LSB-first shifting on i_tick, framing and idle gap.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_frame_controller
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    piso_frame_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = piso_cnt_w(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_TOP    = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_TOP    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       POST_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             done_reg;
    logic             frame_end;
    logic             accept;
    logic             shift_en;
    logic             bit_last;
    logic             shreg_bit;
    logic             in_shift;
    logic             in_par;

    assign accept   = bus.i_valid & (state_reg == ST_IDLE);
    assign shift_en = bus.i_tick & (state_reg == ST_SHIFT);
    assign bit_last = (bit_cnt_reg == '0);

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (accept),
        .shift   (shift_en),
        .din     (bus.i_data),
        .sout    (shreg_bit)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        frame_end    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    bit_cnt_next = BIT_TOP;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.i_tick) begin
                    if (!bit_last) begin
                        bit_cnt_next = bit_cnt_reg - 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_next   = ST_PAR;
`else
                        frame_end    = 1'b1;
                        state_next   = POST_STATE;
                        gap_cnt_next = '0;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                if (bus.i_tick) begin
                    frame_end    = 1'b1;
                    state_next   = POST_STATE;
                    gap_cnt_next = '0;
                end
            end
`endif
            ST_GAP: begin
                // Gap timing runs on the clock, not on i_tick.
                if (gap_cnt_reg == GAP_TOP) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= frame_end;
        end
    end

    assign in_shift = (state_reg == ST_SHIFT);

`ifdef PISO_PARITY_EN
    logic parity_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^bus.i_data;
        end
    end

    assign in_par       = (state_reg == ST_PAR);
    assign bus.o_slast  = in_par;
    assign bus.o_sdata  = (in_shift & shreg_bit) | (in_par & parity_reg);
`else
    assign in_par       = 1'b0;
    assign bus.o_slast  = in_shift & bit_last;
    assign bus.o_sdata  = in_shift & shreg_bit;
`endif

    assign bus.o_ready  = (state_reg == ST_IDLE);
    assign bus.o_svalid = in_shift | in_par;
    assign bus.o_sfirst = in_shift & (bit_cnt_reg == BIT_TOP);
    assign bus.o_done   = done_reg;
endmodule

// File: tb/tb_piso_frame_controller.sv
// Scoreboard bench for piso_frame_controller: stimulus queues expected serial bits, a negedge monitor checks them.
module tb_piso_frame_controller;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int NB  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = W;
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic        is_done;
        logic        sdata;
        logic        sfirst;
        logic        slast;
        int unsigned hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_frame_controller_if #(.WIDTH(W)) bus0 ();
    piso_frame_controller_if #(.WIDTH(W)) bus1 ();

    piso_frame_controller #(.WIDTH(W), .GAP_CYCLES(0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    piso_frame_controller #(.WIDTH(W), .GAP_CYCLES(3)) dut_gap (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned hold_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Monitor: consumes one expected bit per tick-qualified valid cycle and one entry per o_done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus0.o_done) begin
                checks++;
                if (sb.size() == 0 || !sb[0].is_done) begin
                    errors++;
                    $display("FAIL done: o_done=1 but no frame completion expected");
                end else begin
                    void'(sb.pop_front());
                    $display("ok   done: frame completion pulse");
                end
            end
            if (bus0.o_svalid) begin
                hold_cnt++;
                if (bus0.i_tick) begin
                    checks++;
                    if (sb.size() == 0 || sb[0].is_done) begin
                        errors++;
                        $display("FAIL bit: got unexpected bit %b, want no serial bit", bus0.o_sdata);
                    end else begin
                        e = sb.pop_front();
                        if ({bus0.o_sdata, bus0.o_sfirst, bus0.o_slast} !== {e.sdata, e.sfirst, e.slast}
                            || hold_cnt != e.hold) begin
                            errors++;
                            $display("FAIL bit: got data/first/last=%b%b%b hold=%0d want %b%b%b hold=%0d",
                                     bus0.o_sdata, bus0.o_sfirst, bus0.o_slast, hold_cnt,
                                     e.sdata, e.sfirst, e.slast, e.hold);
                        end else begin
                            $display("ok   bit: data/first/last=%b%b%b hold=%0d",
                                     e.sdata, e.sfirst, e.slast, hold_cnt);
                        end
                    end
                    hold_cnt = 0;
                end
            end else begin
                hold_cnt = 0;
                checks++;
                if ({bus0.o_sdata, bus0.o_sfirst, bus0.o_slast} !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_quiet: got data/first/last=%b%b%b want 000",
                             bus0.o_sdata, bus0.o_sfirst, bus0.o_slast);
                end
            end
        end
    end

    task automatic push_frame(input logic [W-1:0] d, input int period);
        for (int i = 0; i < W; i++) begin
            sb.push_back('{1'b0, d[i], (i == 0), (i == W - 1) && !PAR, period});
        end
        if (PAR) sb.push_back('{1'b0, ^d, 1'b0, 1'b1, period});
        sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the last bit is consumed.
    task automatic send_frame(input logic [W-1:0] d, input int period, input logic tick_acc,
                              input logic [W-1:0] next_d, input bit hold_next);
        int n = 0;
        while (!bus0.o_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", bus0.o_ready, 1);
        bus0.i_valid = 1'b1;
        bus0.i_data  = d;
        bus0.i_tick  = tick_acc;
        push_frame(d, period);
        @(posedge clk); #1;
        if (hold_next) begin
            bus0.i_data = next_d;
        end else begin
            bus0.i_valid = 1'b0;
            bus0.i_data  = ~d;
        end
        chk("first_bit", {bus0.o_svalid, bus0.o_sfirst, bus0.o_ready, bus0.o_sdata}, {3'b110, d[0]});
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < period; c++) begin
                bus0.i_tick = (c == period - 1);
                @(posedge clk); #1;
            end
        end
        bus0.i_tick = 1'b0;
        chk("frame_end_ready", {bus0.o_ready, bus0.o_svalid}, 2'b10);
    endtask

    initial begin
        bus0.i_data = '0; bus0.i_valid = 1'b0; bus0.i_tick = 1'b0;
        bus1.i_data = '0; bus1.i_valid = 1'b0; bus1.i_tick = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", bus0.o_ready, 1);
        chk("reset_outs", {bus0.o_svalid, bus0.o_sdata, bus0.o_sfirst, bus0.o_slast, bus0.o_done}, 0);
        chk("reset_gap_ready", bus1.o_ready, 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Constant tick, including a tick on the accept cycle.
        send_frame(4'b1011, 1, 1'b1, 4'b0000, 1'b0);
        chk("done_after_frame", bus0.o_done, 1);

        // Slow tick; the next word is presented mid-frame and must wait for IDLE.
        send_frame(4'b0110, 3, 1'b0, 4'b1001, 1'b1);
        send_frame(4'b1001, 2, 1'b0, 4'b0000, 1'b0);

        // Reset while bit 2 of the frame is on the line.
        bus0.i_valid = 1'b1;
        bus0.i_data  = 4'b1101;
        bus0.i_tick  = 1'b1;
        push_frame(4'b1101, 1);
        @(posedge clk); #1;
        bus0.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bit2_before_reset", {bus0.o_svalid, bus0.o_sdata}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {bus0.o_svalid, bus0.o_sdata, bus0.o_sfirst, bus0.o_slast, bus0.o_done}, 0);
        sb.delete();
        bus0.i_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_release", bus0.o_ready, 1);
        @(posedge clk); #1;
        chk("no_done_after_abort", bus0.o_done, 0);

        send_frame(4'b0101, 1, 1'b1, 4'b0000, 1'b0);
        send_frame(4'b0000, 1, 1'b0, 4'b0000, 1'b0);
        send_frame(4'b1110, 2, 1'b1, 4'b0000, 1'b0);

        // Idle-gap instance: constant tick, three clocks of o_ready low after the frame.
        bus1.i_tick  = 1'b1;
        bus1.i_valid = 1'b1;
        bus1.i_data  = 4'b1011;
        @(posedge clk); #1;
        bus1.i_valid = 1'b0;
        chk("gap_first_bit", {bus1.o_svalid, bus1.o_sfirst, bus1.o_sdata}, 3'b111);
        for (int i = 1; i < NB; i++) begin
            @(posedge clk); #1;
        end
        chk("gap_last_bit", {bus1.o_svalid, bus1.o_slast}, 2'b11);
        @(posedge clk); #1;
        chk("gap_done", bus1.o_done, 1);
        for (int g = 0; g < 3; g++) begin
            chk("gap_ready_low", {bus1.o_ready, bus1.o_svalid}, 2'b00);
            @(posedge clk); #1;
        end
        chk("gap_ready_back", bus1.o_ready, 1);
        bus1.i_tick = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
